// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared types: access lengths, FSM states, IO region, byte counts.
// Imported by the controller, its bus interface and the bench.
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  typedef enum logic [1:0] {
    LEN_B  = 2'b00,
    LEN_H  = 2'b01,
    LEN_W  = 2'b10,
    LEN_W2 = 2'b11
  } mem_len_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IF_RD,
    S_D_RD,
    S_D_WR
  } state_e;

  function automatic logic [2:0] byte_cnt(input mem_len_e len);
    logic [2:0] n;
    unique case (len)
      LEN_B:   n = 3'd1;
      LEN_H:   n = 3'd2;
      LEN_W:   n = 3'd4;
      LEN_W2:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl bundle: fetch port, data port and the byte-wide RAM/IO bus.
// master = core + RAM side, slave = the controller.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_clear;
  logic [31:0]       if_data;
  logic              if_done;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [1:0]        d_len;
  logic [31:0]       d_rdata;
  logic              d_done;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    output if_req, if_addr, if_clear,
    input  if_data, if_done,
    output d_read, d_write, d_addr, d_wdata, d_len,
    input  d_rdata, d_done,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, if_clear,
    output if_data, if_done,
    input  d_read, d_write, d_addr, d_wdata, d_len,
    output d_rdata, d_done,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: fetch and data requests in, one bus
// byte per cycle out, little-endian result with a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  mem_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        n_q;
  logic [2:0]        i_q;
  logic              p_vld_q;
  logic [1:0]        p_idx_q;
  logic [31:0]       buf_q;
  logic [31:0]       if_data_q;
  logic [31:0]       d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;

  logic [ADDR_W-1:0] cur_a;
  logic              more;
  logic              io_hold;
  logic              issue_rd;
  logic              issue_wr;
  logic              rd_fin;
  logic              wr_fin;
  logic              acc_d;
  logic              acc_if;
  logic [31:0]       rd_buf;

  assign cur_a   = addr_q + ADDR_W'(i_q);
  assign more    = i_q < n_q;
  assign io_hold = (cur_a[17:16] == IO_SEL)
                 && bus.io_buffer_full;

  // A fetch being cleared issues nothing more.
  assign issue_rd = rdy_in && more
    && (state_q == S_D_RD
        || (state_q == S_IF_RD && !bus.if_clear));
  assign issue_wr = rdy_in && more
    && state_q == S_D_WR && !io_hold;

  assign rd_fin = rdy_in && !more
    && (state_q == S_D_RD || state_q == S_IF_RD);
  assign wr_fin = issue_wr && (i_q == n_q - 3'd1);

  assign acc_d  = state_q == S_IDLE && rdy_in
    && (bus.d_read || bus.d_write);
  assign acc_if = state_q == S_IDLE && rdy_in
    && !(bus.d_read || bus.d_write)
    && bus.if_req && !bus.if_clear;

  // The byte issued last cycle lands now, even in a frozen cycle.
  always_comb begin
    rd_buf = buf_q;
    if (p_vld_q)
      rd_buf[{p_idx_q, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rdy_in) begin
          if (bus.d_read)       state_d = S_D_RD;
          else if (bus.d_write) state_d = S_D_WR;
          else if (acc_if)      state_d = S_IF_RD;
        end
      end
      S_IF_RD: begin
        if (bus.if_clear || rd_fin) state_d = S_IDLE;
      end
      S_D_RD: begin
        if (rd_fin) state_d = S_IDLE;
      end
      S_D_WR: begin
        if (wr_fin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    if (issue_rd) begin
      bus.mem_a = cur_a;
    end
    if (issue_wr) begin
      bus.mem_a    = cur_a;
      bus.mem_dout = wdata_q[{i_q[1:0], 3'b000} +: 8];
      bus.mem_wr   = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      n_q       <= '0;
      i_q       <= '0;
      p_vld_q   <= 1'b0;
      p_idx_q   <= '0;
      buf_q     <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      p_vld_q   <= issue_rd;
      p_idx_q   <= i_q[1:0];
      buf_q     <= rd_buf;
      if (issue_rd || issue_wr)
        i_q <= i_q + 3'd1;
      if (acc_d || acc_if) begin
        addr_q  <= acc_d ? bus.d_addr : bus.if_addr;
        n_q     <= acc_d
          ? byte_cnt(mem_len_e'(bus.d_len)) : 3'd4;
        wdata_q <= bus.d_wdata;
        i_q     <= '0;
        buf_q   <= '0;
      end
      if (rd_fin) begin
        if (state_q == S_D_RD) begin
          d_rdata_q <= rd_buf;
          d_done_q  <= 1'b1;
        end else if (!bus.if_clear) begin
          if_data_q <= rd_buf;
          if_done_q <= 1'b1;
        end
      end
      if (wr_fin)
        d_done_q <= 1'b1;
    end
  end

  assign bus.if_data = if_data_q;
  assign bus.if_done = if_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_done  = d_done_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU core and the byte-wide unified RAM/IO bus.
- Accepts word/half/byte requests from two sides: instruction fetch (IF side) and data access (MEM stage, ram_* side).
- Serialises each request into consecutive single-byte bus transactions and returns the assembled little-endian result with a one-cycle done pulse.
- Sits directly under cpu, on the far side of the ram_*/rom_* request signals.

Parameters:
- ADDR_W, 32, address width of both requesters and of mem_a
- IO_SEL, 2'b11, value of mem_a[17:16] that selects the IO region

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-high
- rdy_in  in  1  0 = freeze controller
- if_req  in  1  fetch request; level, held until if_done
- if_addr  in  32  fetch byte address
- if_clear  in  1  abort current/pending fetch (jump taken)
- if_data  out  32  fetched instruction
- if_done  out  1  one-cycle pulse; if_data valid
- d_read  in  1  data read request; level
- d_write  in  1  data write request; level; never together with d_read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_len  in  2  00 byte, 01 half, 10 word (11 treated as word)
- d_rdata  out  32  read result, zero-extended
- d_done  out  1  one-cycle pulse; read data valid or write committed
- mem_din  in  8  bus read data (returned one cycle after address)
- mem_dout  out  8  bus write data
- mem_a  out  32  bus address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset, synchronous: state IDLE; mem_a, mem_dout, mem_wr, if_data, d_rdata, if_done and d_done all 0.
- Reset mid-operation: the transfer is abandoned; mem_wr is 0 in the cycle after the reset edge; no done pulse is issued.
- States: IDLE, IF_RD, D_RD, D_WR.
- IDLE arbitration, on an edge with rdy_in=1:
  - d_read or d_write pending wins: go to D_RD or D_WR.
  - else if_req pending and if_clear=0: go to IF_RD.
  - Latch address, length (IF is always 4 bytes), wdata; byte index i=0.
- Byte access i:
  - mem_a = latched addr + i, modulo 2^32; misaligned addresses are allowed.
  - Write: mem_dout = wdata[8i+7:8i].
  - Idle bus (IDLE state or a frozen cycle): mem_a=0, mem_wr=0, mem_dout=0.
- Reads are pipelined:
  - One address is issued per cycle for i=0..N-1.
  - mem_din is captured one cycle later into result bits [8i+7:8i].
  - The done pulse comes in the cycle after the last capture, so read latency is N+2 cycles from the accept edge to done high.
  - Upper bytes not read are 0.
- Writes:
  - One byte per cycle with mem_wr=1.
  - d_done pulses in the cycle after the last byte, so write latency is N+1 cycles from accept to done.
- IO write hold: while mem_a[17:16]==IO_SEL and io_buffer_full=1, the byte is not issued (mem_wr=0) and i is held; it is reissued once io_buffer_full=0.
- rdy_in=0:
  - No new bus access is issued, i is frozen, mem_wr=0, and no request is accepted.
  - A read byte issued in the previous ready cycle is still captured.
  - Done pulses are deferred until rdy_in=1.
- After done, return to IDLE. The next request can be accepted on the edge following the done cycle; requesters must drop their request on done.
- if_clear:
  - In IF_RD: abandon the fetch and go to IDLE next cycle; no if_done.
  - Coincident with the if_done cycle: if_done is suppressed and if_data is left unchanged.
  - if_clear never affects data transfers.
- A data request arriving during a fetch waits; the fetch is not preempted.
- done outputs are high for exactly one cycle; if_data and d_rdata hold their values until the next completion.

Decomposition:
- config.vh gains:
  - d_len encodings (memwType width 2)
  - state encodings
  - IO_SEL region constant
  - byte-count function/table (len -> 1/2/4)
- Single module. No sub-module is natural: the byte sequencer is shared by all three active states.

Test Plan:
- d_read word at 0x100, RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles; d_rdata=0x44332211; d_done 6 cycles after the accept edge.
- d_write byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr held 0 for 3 cycles, then one cycle of mem_wr=1, mem_dout=0x41; d_done next cycle.
- if_req @0x0 and d_read half @0x200 (bytes AA,BB) asserted together -> data served first, d_rdata=0x0000BBAA; then fetch; if_done once.
- if_clear raised at i=2 of a fetch -> no if_done; state IDLE next cycle; bus idle.
- rdy_in low for 2 cycles mid word-read, then high -> correct data; done delayed by exactly 2 cycles.
- rst_in during a word write at i=1 -> mem_wr=0 next cycle; no d_done; a new request is accepted normally after reset.
